// File: rtl/psychic5_loader_pkg.sv
// psychic5_loader_pkg: shared FSM/region types and default download-image layout.
package psychic5_loader_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
  typedef enum logic [2:0] {R_NONE, R_SDRAM, R_SOUND, R_TMBG, R_TMFG, R_GRAY, R_SEQ} region_t;
  localparam logic [24:0] SOUNDROM_BASE_DEF = 25'h40000;
  localparam logic [24:0] TMBGROM_BASE_DEF  = 25'h48000;
  localparam logic [24:0] TMFGROM_BASE_DEF  = 25'h68000;
  localparam logic [24:0] GRAYLUT_BASE_DEF  = 25'h70000;
  localparam logic [24:0] SEQROM_BASE_DEF   = 25'h70100;
  localparam logic [24:0] IMAGE_END_DEF     = 25'h70200;
  // Active-low chip selects ordered {sound, tmbg, tmfg, gray, seq}
  function automatic logic [4:0] region_cs_n(region_t r);
    return r == R_SOUND ? 5'b01111 :
           r == R_TMBG  ? 5'b10111 :
           r == R_TMFG  ? 5'b11011 :
           r == R_GRAY  ? 5'b11101 :
           r == R_SEQ   ? 5'b11110 : 5'b11111;
  endfunction
endpackage

// File: rtl/psychic5_region_decode.sv
// psychic5_region_decode: maps a download offset to its target region and region-relative address.
module psychic5_region_decode
  import psychic5_loader_pkg::*;
#(
  parameter logic [24:0] SOUNDROM_BASE = SOUNDROM_BASE_DEF,
  parameter logic [24:0] TMBGROM_BASE  = TMBGROM_BASE_DEF,
  parameter logic [24:0] TMFGROM_BASE  = TMFGROM_BASE_DEF,
  parameter logic [24:0] GRAYLUT_BASE  = GRAYLUT_BASE_DEF,
  parameter logic [24:0] SEQROM_BASE   = SEQROM_BASE_DEF,
  parameter logic [24:0] IMAGE_END     = IMAGE_END_DEF
) (
  input  logic [24:0] i_addr,
  output region_t     o_region,
  output logic [16:0] o_rel
);
  logic [16:0] base;
  assign o_region = i_addr < SOUNDROM_BASE ? R_SDRAM :
                    i_addr < TMBGROM_BASE  ? R_SOUND :
                    i_addr < TMFGROM_BASE  ? R_TMBG  :
                    i_addr < GRAYLUT_BASE  ? R_TMFG  :
                    i_addr < SEQROM_BASE   ? R_GRAY  :
                    i_addr < IMAGE_END     ? R_SEQ   : R_NONE;
  assign base = o_region == R_SOUND ? SOUNDROM_BASE[16:0] :
                o_region == R_TMBG  ? TMBGROM_BASE[16:0]  :
                o_region == R_TMFG  ? TMFGROM_BASE[16:0]  :
                o_region == R_GRAY  ? GRAYLUT_BASE[16:0]  :
                o_region == R_SEQ   ? SEQROM_BASE[16:0]   : 17'd0;
  // Subtracting in 17 bits gives the same result as the full-width difference truncated
  assign o_rel = i_addr[16:0] - base;
endmodule

// File: rtl/psychic5_bram_loader.sv
// psychic5_bram_loader: turns the ROM-download byte stream into timed BRAM programming-bus writes
// with a one-byte skid buffer, and holds the core in soft reset while a download runs.
module psychic5_bram_loader
  import psychic5_loader_pkg::*;
#(
  parameter logic [24:0] SOUNDROM_BASE = SOUNDROM_BASE_DEF,
  parameter logic [24:0] TMBGROM_BASE  = TMBGROM_BASE_DEF,
  parameter logic [24:0] TMFGROM_BASE  = TMFGROM_BASE_DEF,
  parameter logic [24:0] GRAYLUT_BASE  = GRAYLUT_BASE_DEF,
  parameter logic [24:0] SEQROM_BASE   = SEQROM_BASE_DEF,
  parameter logic [24:0] IMAGE_END     = IMAGE_END_DEF,
  parameter int unsigned WR_PULSE      = 2
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST_n,
  input  logic        i_DL_EN,
  input  logic [24:0] i_DL_ADDR,
  input  logic [7:0]  i_DL_DATA,
  input  logic        i_DL_WR,
  output logic        o_DL_WAIT,
  output logic        o_DL_OVERRUN,
  output logic        o_DL_SDRAM_SEL,
  output logic [16:0] o_EMU_BRAM_ADDR,
  output logic [7:0]  o_EMU_BRAM_DATA,
  output logic        o_EMU_BRAM_WR_n,
  output logic        o_EMU_BRAM_SOUNDROM_CS_n,
  output logic        o_EMU_BRAM_TMBGROM_CS_n,
  output logic        o_EMU_BRAM_TMFGROM_CS_n,
  output logic        o_EMU_BRAM_GRAYLUT_CS_n,
  output logic        o_EMU_BRAM_SEQROM_CS_n,
  output logic        o_EMU_SOFTRST_n,
  output logic        o_LOAD_DONE
);
  region_t     region;
  logic [16:0] rel;
  psychic5_region_decode #(
    .SOUNDROM_BASE(SOUNDROM_BASE), .TMBGROM_BASE(TMBGROM_BASE), .TMFGROM_BASE(TMFGROM_BASE),
    .GRAYLUT_BASE(GRAYLUT_BASE), .SEQROM_BASE(SEQROM_BASE), .IMAGE_END(IMAGE_END)
  ) u_dec (
    .i_addr(i_DL_ADDR),
    .o_region(region),
    .o_rel(rel)
  );
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d, skid_addr_q, skid_addr_d;
  logic [7:0]  data_q, data_d, skid_data_q, skid_data_d;
  logic [4:0]  sel_q, sel_d, skid_sel_q, skid_sel_d, cs_n_q, cs_n_d;
  logic        skid_vld_q, skid_vld_d, wr_n_q, wr_n_d, sdram_sel_q, sdram_sel_d;
  logic        overrun_q, overrun_d, softrst_n_q, softrst_n_d, load_done_q, load_done_d;
  logic        dl_en_q, got_q, got_d, fall_pend_q, fall_pend_d;
  logic [4:0]  new_sel;
  logic        free, is_bram, launch, skid_we, drop, rise, fall, release_now;
  always_comb begin
    new_sel     = region_cs_n(region);
    // HOLD ends this edge, so the FSM may accept a new launch just like in IDLE
    free        = state_q == S_IDLE || state_q == S_HOLD;
    is_bram     = i_DL_WR && new_sel != 5'h1f;
    launch      = free && (skid_vld_q || is_bram);
    drop        = is_bram && !free && skid_vld_q;
    skid_we     = is_bram && (free ? skid_vld_q : !skid_vld_q);
    state_d     = launch ? S_SETUP :
                  state_q == S_SETUP ? S_STROBE :
                  state_q == S_STROBE ? (cnt_q == 4'd0 ? S_HOLD : S_STROBE) : S_IDLE;
    cnt_d       = state_q == S_SETUP ? 4'(WR_PULSE - 1) : cnt_q - {3'b0, state_q == S_STROBE};
    addr_d      = launch ? (skid_vld_q ? skid_addr_q : rel) : addr_q;
    data_d      = launch ? (skid_vld_q ? skid_data_q : i_DL_DATA) : data_q;
    sel_d       = launch ? (skid_vld_q ? skid_sel_q : new_sel) : sel_q;
    skid_addr_d = skid_we ? rel : skid_addr_q;
    skid_data_d = skid_we ? i_DL_DATA : skid_data_q;
    skid_sel_d  = skid_we ? new_sel : skid_sel_q;
    skid_vld_d  = free ? (skid_vld_q && is_bram) : (skid_vld_q || is_bram);
    overrun_d   = overrun_q || drop;
    sdram_sel_d = i_DL_WR && region == R_SDRAM;
    wr_n_d      = state_d != S_STROBE;
    cs_n_d      = state_d == S_IDLE ? 5'h1f : sel_d;
    rise        = i_DL_EN && !dl_en_q;
    fall        = !i_DL_EN && dl_en_q;
    got_d       = (got_q && !rise) || (i_DL_WR && region != R_NONE && !drop);
    release_now = (fall_pend_q || fall) && !rise && state_d == S_IDLE && !skid_vld_d;
    fall_pend_d = (fall_pend_q || fall) && !rise && !release_now;
    softrst_n_d = rise ? 1'b0 : (release_now && got_d) ? 1'b1 : softrst_n_q;
    load_done_d = rise ? 1'b0 : (release_now && got_d) ? 1'b1 : load_done_q;
  end
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= 5'h1f;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= 5'h1f;
      skid_vld_q  <= 1'b0;
      wr_n_q      <= 1'b1;
      cs_n_q      <= 5'h1f;
      sdram_sel_q <= 1'b0;
      overrun_q   <= 1'b0;
      softrst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      dl_en_q     <= 1'b0;
      got_q       <= 1'b0;
      fall_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_vld_q  <= skid_vld_d;
      wr_n_q      <= wr_n_d;
      cs_n_q      <= cs_n_d;
      sdram_sel_q <= sdram_sel_d;
      overrun_q   <= overrun_d;
      softrst_n_q <= softrst_n_d;
      load_done_q <= load_done_d;
      dl_en_q     <= i_DL_EN;
      got_q       <= got_d;
      fall_pend_q <= fall_pend_d;
    end
  end
  assign o_DL_WAIT                = skid_vld_q;
  assign o_DL_OVERRUN             = overrun_q;
  assign o_DL_SDRAM_SEL           = sdram_sel_q;
  assign o_EMU_BRAM_ADDR          = addr_q;
  assign o_EMU_BRAM_DATA          = data_q;
  assign o_EMU_BRAM_WR_n          = wr_n_q;
  assign o_EMU_BRAM_SOUNDROM_CS_n = cs_n_q[4];
  assign o_EMU_BRAM_TMBGROM_CS_n  = cs_n_q[3];
  assign o_EMU_BRAM_TMFGROM_CS_n  = cs_n_q[2];
  assign o_EMU_BRAM_GRAYLUT_CS_n  = cs_n_q[1];
  assign o_EMU_BRAM_SEQROM_CS_n   = cs_n_q[0];
  assign o_EMU_SOFTRST_n          = softrst_n_q;
  assign o_LOAD_DONE              = load_done_q;
endmodule

// File: tb/tb_psychic5_bram_loader.sv
// tb_psychic5_bram_loader: directed and randomized checks of the BRAM loader against a
// timeline model of write slots and a one-byte waiting buffer.
module tb_psychic5_bram_loader;
  localparam int WR_PULSE = 2;
  localparam int SLOT = WR_PULSE + 2;
  logic clk = 1'b0, rst_n = 1'b0, dl_en = 1'b0, dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic dl_wait, overrun, sdram_sel, wr_n, softrst_n, load_done;
  logic cs_sound, cs_tmbg, cs_tmfg, cs_gray, cs_seq;
  logic [16:0] addr;
  logic [7:0]  data;
  logic [4:0]  cs;
  assign cs = {cs_sound, cs_tmbg, cs_tmfg, cs_gray, cs_seq};
  psychic5_bram_loader #(.WR_PULSE(WR_PULSE)) dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n), .i_DL_EN(dl_en), .i_DL_ADDR(dl_addr),
    .i_DL_DATA(dl_data), .i_DL_WR(dl_wr), .o_DL_WAIT(dl_wait), .o_DL_OVERRUN(overrun),
    .o_DL_SDRAM_SEL(sdram_sel), .o_EMU_BRAM_ADDR(addr), .o_EMU_BRAM_DATA(data),
    .o_EMU_BRAM_WR_n(wr_n), .o_EMU_BRAM_SOUNDROM_CS_n(cs_sound),
    .o_EMU_BRAM_TMBGROM_CS_n(cs_tmbg), .o_EMU_BRAM_TMFGROM_CS_n(cs_tmfg),
    .o_EMU_BRAM_GRAYLUT_CS_n(cs_gray), .o_EMU_BRAM_SEQROM_CS_n(cs_seq),
    .o_EMU_SOFTRST_n(softrst_n), .o_LOAD_DONE(load_done)
  );
  always #5 clk = ~clk;
  typedef struct { int t; logic [4:0] cs; logic [16:0] addr; logic [7:0] data; } wr_t;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  wr_t got_q[$];
  int sdram_cnt = 0, onehot_bad = 0;
  logic wr_prev = 1'b1;
  // Every write is recorded once, when WR_n first goes low; t is the edge that launched it
  always @(negedge clk) begin
    if (!wr_n && wr_prev) got_q.push_back('{cyc - 1, cs, addr, data});
    if (sdram_sel) sdram_cnt++;
    if (cs != 5'h1f && $countones(~cs) != 1) onehot_bad++;
    wr_prev = wr_n;
  end
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr = 1'b1;
    step();
    dl_wr = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask
  // Reference decode: idx 0..4 = sound..seq, -1 = SDRAM, -2 = outside image
  function automatic void decode(input logic [24:0] a, output int idx, output logic [16:0] rel);
    int b[6] = '{'h40000, 'h48000, 'h68000, 'h70000, 'h70100, 'h70200};
    idx = a < 25'(b[0]) ? -1 : -2;
    rel = '0;
    for (int i = 0; i < 5; i++)
      if (a >= 25'(b[i]) && a < 25'(b[i+1])) begin
        idx = i;
        rel = 17'(int'(a) - b[i]);
      end
  endfunction
  function automatic logic [4:0] cs_of(input int idx);
    logic [4:0] one = 5'b10000;
    return ~(one >> idx);
  endfunction
  initial begin
    int base, idx, next_free, exp_sd, sd_base, t3;
    bit pend, exp_ovr;
    logic [16:0] rel;
    logic [24:0] a;
    logic [7:0] d;
    wr_t pend_w, w;
    wr_t exp_q[$];
    logic [24:0] reg_addr[4] = '{25'h48000, 25'h6FFFF, 25'h70000, 25'h701FF};
    logic [16:0] reg_rel[4]  = '{17'h0, 17'h7FFF, 17'h0, 17'hFF};
    logic [4:0]  reg_cs[4]   = '{5'b10111, 5'b11011, 5'b11101, 5'b11110};
    step(2);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_cs_n", cs, 5'h1f);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_wait", dl_wait, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sdram", sdram_sel, 0);
    chk("rst_softrst", softrst_n, 0);
    chk("rst_done", load_done, 0);
    rst_n = 1'b1;
    step(3);
    // Single sound write and its exact cycle timing
    strobe(25'h40005, 8'hA5);
    chk("t1_cs", cs, 5'b01111);
    chk("t1_addr", addr, 5);
    chk("t1_data", data, 8'hA5);
    chk("t1_wr_setup", wr_n, 1);
    step();
    chk("t1_wr_lo1", wr_n, 0);
    step();
    chk("t1_wr_lo2", wr_n, 0);
    step();
    chk("t1_wr_hold", wr_n, 1);
    chk("t1_cs_hold", cs, 5'b01111);
    step();
    chk("t1_cs_idle", cs, 5'h1f);
    // Region boundaries
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      strobe(reg_addr[i], d);
      chk("t2_addr", addr, reg_rel[i]);
      chk("t2_cs", cs, reg_cs[i]);
      chk("t2_data", data, d);
      step(5);
    end
    // SDRAM byte and out-of-image byte never touch the BRAM bus
    base = got_q.size();
    strobe(25'h1FFFF, 8'h11);
    chk("t3_sdram_pulse", sdram_sel, 1);
    chk("t3_sdram_cs", cs, 5'h1f);
    step();
    chk("t3_sdram_end", sdram_sel, 0);
    chk("t3_sdram_wr", wr_n, 1);
    strobe(25'h70200, 8'h22);
    chk("t3_none_sdram", sdram_sel, 0);
    chk("t3_none_cs", cs, 5'h1f);
    step(3);
    chk("t3_none_wr", wr_n, 1);
    chk("t3_no_writes", got_q.size(), base);
    // Back-to-back strobes: second waits, third is dropped
    base = got_q.size();
    strobe(25'h40010, 8'h11);
    strobe(25'h40011, 8'h22);
    chk("t4_wait", dl_wait, 1);
    strobe(25'h40012, 8'h33);
    chk("t4_overrun", overrun, 1);
    step(15);
    chk("t4_count", got_q.size(), base + 2);
    if (got_q.size() >= base + 2) begin
      chk("t4_data1", got_q[base].data, 8'h11);
      chk("t4_data2", got_q[base+1].data, 8'h22);
    end
    chk("t4_wait_clr", dl_wait, 0);
    // Randomized stream against a slot-timeline model
    do_reset();
    base = got_q.size();
    sd_base = sdram_cnt;
    next_free = 0;
    pend = 0;
    exp_ovr = 0;
    exp_sd = 0;
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0: a = 25'($urandom_range(0, 'h3FFFF));
        1: a = 25'($urandom_range('h70200, 'h7FFFF));
        default: a = 25'($urandom_range('h40000, 'h701FF));
      endcase
      d = 8'($urandom);
      strobe(a, d);
      decode(a, idx, rel);
      if (idx == -1) exp_sd++;
      if (idx >= 0) begin
        if (pend && next_free <= cyc) begin
          pend_w.t = next_free;
          exp_q.push_back(pend_w);
          next_free += SLOT;
          pend = 0;
        end
        w = '{cyc, cs_of(idx), rel, d};
        if (cyc >= next_free) begin
          exp_q.push_back(w);
          next_free = cyc + SLOT;
        end else if (!pend) begin
          pend = 1;
          pend_w = w;
        end else exp_ovr = 1;
      end
    end
    if (pend) begin
      pend_w.t = next_free;
      exp_q.push_back(pend_w);
    end
    step(12);
    chk("rnd_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      chk("rnd_time", got_q[base+i].t, exp_q[i].t);
      chk("rnd_cs", got_q[base+i].cs, exp_q[i].cs);
      chk("rnd_addr", got_q[base+i].addr, exp_q[i].addr);
      chk("rnd_data", got_q[base+i].data, exp_q[i].data);
    end
    chk("rnd_overrun", overrun, exp_ovr);
    chk("rnd_sdram_cnt", sdram_cnt - sd_base, exp_sd);
    // Download control: release soft reset when the last write's HOLD ends
    do_reset();
    dl_en = 1'b1;
    step(2);
    chk("dl_softrst_on", softrst_n, 0);
    chk("dl_done_off", load_done, 0);
    for (int k = 0; k < 3; k++) begin
      strobe(25'h40100 + 25'(k), 8'(k + 1));
      if (k < 2) step(6);
    end
    dl_en = 1'b0;
    t3 = cyc;
    step();
    chk("dl_held1", softrst_n, 0);
    step(2);
    chk("dl_hold_cyc", cyc, t3 + 3);
    chk("dl_held_hold", softrst_n, 0);
    chk("dl_done_hold", load_done, 0);
    chk("dl_cs_hold", cs, 5'b01111);
    step();
    chk("dl_released", softrst_n, 1);
    chk("dl_done", load_done, 1);
    chk("dl_cs_idle", cs, 5'h1f);
    dl_en = 1'b1;
    step(2);
    chk("dl0_softrst_on", softrst_n, 0);
    chk("dl0_done_clr", load_done, 0);
    dl_en = 1'b0;
    step(6);
    chk("dl0_stays", softrst_n, 0);
    chk("dl0_no_done", load_done, 0);
    // Asynchronous reset in the middle of the strobe phase
    strobe(25'h40020, 8'h5A);
    step();
    chk("ar_wr_lo", wr_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wr_n", wr_n, 1);
    chk("ar_cs_n", cs, 5'h1f);
    chk("ar_addr", addr, 0);
    step();
    rst_n = 1'b1;
    step(6);
    chk("ar_idle_cs", cs, 5'h1f);
    chk("cs_onehot_viol", onehot_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
